// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to a sync-read imem and buffers {addr, instr}.
// Latency: issue at t -> head visible at t+2 (empty queue); redirect -> first entry at t+3.
// Backpressure: stall holds the head; issue is credit-limited by count + inflight < DEPTH.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter int               PC_STEP  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [WIDTH-1:0]           imem_addr,
    input  logic [WIDTH-1:0]           imem_rdata,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_addr,
    input  logic                       stall,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_instr,
    output logic [WIDTH-1:0]           out_addr,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [WIDTH-1:0] fetch_pc_q;
    logic [WIDTH-1:0] inflight_addr_q;
    logic             inflight_q;
    logic             squash_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic [CW:0]      occupancy;
    logic             issue;
    logic             push;
    logic             pop;
    entry_t           head;

    // Outstanding fetch reserves a slot so its response always has room.
    assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q);
    assign issue     = ~reset & ~redirect & (occupancy < (CW + 1)'(DEPTH));
    assign push      = inflight_q & ~squash_q & ~redirect;
    assign pop       = out_valid & ~stall & ~redirect;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign out_instr = out_valid ? head.instr : '0;
    assign out_addr  = out_valid ? head.addr  : '0;
    assign count     = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q      <= RESET_PC;
            inflight_addr_q <= '0;
            inflight_q      <= 1'b0;
            squash_q        <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            inflight_q <= issue;
            squash_q   <= redirect & inflight_q;
            if (issue) begin
                inflight_addr_q <= fetch_pc_q;
            end
            if (redirect) begin
                fetch_pc_q <= redirect_addr;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + STEP;
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (push & ~pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop & ~push) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: inflight_addr_q, instr: imem_rdata};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: default instance plus a RESET_PC=0xFFFFFFF8 instance for address wrap.
module tb_fetch_queue;
    localparam logic [31:0] K    = 32'h1000_0000;
    localparam logic [31:0] IDLE = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;

    logic        req, ov, w_req, w_ov;
    logic [31:0] addr, rdata, oi, oa, w_addr, w_rdata, w_oi, w_oa;
    logic [2:0]  cnt, w_cnt;

    int vec = 0;
    int miss = 0;

    always #5 clk = ~clk;

    // Synchronous-read memory model: word = address + K.
    always @(posedge clk) rdata   <= req   ? addr + K   : IDLE;
    always @(posedge clk) w_rdata <= w_req ? w_addr + K : IDLE;

    fetch_queue dut (
        .clk(clk), .reset(reset), .imem_req(req), .imem_addr(addr), .imem_rdata(rdata),
        .redirect(redirect), .redirect_addr(redirect_addr), .stall(stall),
        .out_valid(ov), .out_instr(oi), .out_addr(oa), .count(cnt)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect(redirect), .redirect_addr(redirect_addr), .stall(stall),
        .out_valid(w_ov), .out_instr(w_oi), .out_addr(w_oa), .count(w_cnt)
    );

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic hold_reset();
        adv();
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        adv();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        adv();
        adv();
        #1;
        vec++; if (req !== 1'b0) begin miss++; $display("FAIL rst_req got %0h want 0", req); end
        vec++; if (addr !== 32'h0) begin miss++; $display("FAIL rst_addr got %0h want 0", addr); end
        vec++; if (ov !== 1'b0) begin miss++; $display("FAIL rst_valid got %0h want 0", ov); end
        vec++; if (oi !== 32'h0) begin miss++; $display("FAIL rst_instr got %0h want 0", oi); end
        vec++; if (oa !== 32'h0) begin miss++; $display("FAIL rst_oaddr got %0h want 0", oa); end
        vec++; if (cnt !== 3'd0) begin miss++; $display("FAIL rst_count got %0d want 0", cnt); end
        vec++; if (w_addr !== 32'hFFFF_FFF8) begin miss++; $display("FAIL rst_w_addr got %0h want fffffff8", w_addr); end
        vec++; if (w_req !== 1'b0) begin miss++; $display("FAIL rst_w_req got %0h want 0", w_req); end
    endtask

    task automatic test_stream();
        hold_reset();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            vec++; if (req !== 1'b1) begin miss++; $display("FAIL stream_req c%0d got %0h want 1", c, req); end
            vec++; if (addr !== 32'(c * 4)) begin miss++; $display("FAIL stream_addr c%0d got %0h want %0h", c, addr, c * 4); end
            if (c >= 2) begin
                vec++; if (ov !== 1'b1) begin miss++; $display("FAIL stream_valid c%0d got %0h want 1", c, ov); end
                vec++; if (oa !== 32'((c - 2) * 4)) begin miss++; $display("FAIL stream_oaddr c%0d got %0h want %0h", c, oa, (c - 2) * 4); end
                vec++; if (oi !== 32'((c - 2) * 4) + K) begin miss++; $display("FAIL stream_instr c%0d got %0h want %0h", c, oi, 32'((c - 2) * 4) + K); end
                vec++; if (cnt !== 3'd1) begin miss++; $display("FAIL stream_count c%0d got %0d want 1", c, cnt); end
            end else begin
                vec++; if (ov !== 1'b0) begin miss++; $display("FAIL stream_early_valid c%0d got %0h want 0", c, ov); end
            end
        end
    endtask

    task automatic test_stall();
        hold_reset();
        reset = 1'b0;
        stall = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            vec++; if (req !== (c < 4)) begin miss++; $display("FAIL stall_req c%0d got %0h want %0h", c, req, c < 4); end
            if (c < 4) begin
                vec++; if (addr !== 32'(c * 4)) begin miss++; $display("FAIL stall_addr c%0d got %0h want %0h", c, addr, c * 4); end
            end
            if (c == 4) begin
                vec++; if (cnt !== 3'd3) begin miss++; $display("FAIL stall_count3 got %0d want 3", cnt); end
            end
            if (c >= 5) begin
                vec++; if (cnt !== 3'd4) begin miss++; $display("FAIL stall_full c%0d got %0d want 4", c, cnt); end
                vec++; if (oa !== 32'h0) begin miss++; $display("FAIL stall_head c%0d got %0h want 0", c, oa); end
                vec++; if (addr !== 32'h10) begin miss++; $display("FAIL stall_pc c%0d got %0h want 10", c, addr); end
            end
        end
        adv();
        stall = 1'b0;
        #1;
        vec++; if (oa !== 32'h0) begin miss++; $display("FAIL drain_a0 got %0h want 0", oa); end
        vec++; if (req !== 1'b0) begin miss++; $display("FAIL drain_req0 got %0h want 0", req); end
        step();
        vec++; if (oa !== 32'h4) begin miss++; $display("FAIL drain_a4 got %0h want 4", oa); end
        vec++; if (cnt !== 3'd3) begin miss++; $display("FAIL drain_count got %0d want 3", cnt); end
        vec++; if (req !== 1'b1) begin miss++; $display("FAIL drain_req1 got %0h want 1", req); end
        vec++; if (addr !== 32'h10) begin miss++; $display("FAIL drain_resume got %0h want 10", addr); end
        step();
        vec++; if (oa !== 32'h8) begin miss++; $display("FAIL drain_a8 got %0h want 8", oa); end
        step();
        vec++; if (oa !== 32'hC) begin miss++; $display("FAIL drain_aC got %0h want c", oa); end
        step();
        vec++; if (oa !== 32'h10) begin miss++; $display("FAIL drain_a10 got %0h want 10", oa); end
        vec++; if (oi !== 32'h10 + K) begin miss++; $display("FAIL drain_i10 got %0h want %0h", oi, 32'h10 + K); end
    endtask

    task automatic test_redirect();
        hold_reset();
        reset = 1'b0;
        stall = 1'b1;
        #1;
        step();
        step();
        adv();
        redirect = 1'b1;
        redirect_addr = 32'h100;
        #1;
        vec++; if (cnt !== 3'd2) begin miss++; $display("FAIL redir_pre_count got %0d want 2", cnt); end
        vec++; if (req !== 1'b0) begin miss++; $display("FAIL redir_no_issue got %0h want 0", req); end
        adv();
        redirect = 1'b0;
        stall = 1'b0;
        #1;
        vec++; if (ov !== 1'b0) begin miss++; $display("FAIL redir_t1_valid got %0h want 0", ov); end
        vec++; if (cnt !== 3'd0) begin miss++; $display("FAIL redir_t1_count got %0d want 0", cnt); end
        vec++; if (oa !== 32'h0) begin miss++; $display("FAIL redir_t1_oaddr got %0h want 0", oa); end
        vec++; if (req !== 1'b1) begin miss++; $display("FAIL redir_t1_req got %0h want 1", req); end
        vec++; if (addr !== 32'h100) begin miss++; $display("FAIL redir_t1_addr got %0h want 100", addr); end
        step();
        vec++; if (ov !== 1'b0) begin miss++; $display("FAIL redir_t2_valid got %0h want 0", ov); end
        vec++; if (addr !== 32'h104) begin miss++; $display("FAIL redir_t2_addr got %0h want 104", addr); end
        step();
        vec++; if (ov !== 1'b1) begin miss++; $display("FAIL redir_t3_valid got %0h want 1", ov); end
        vec++; if (oa !== 32'h100) begin miss++; $display("FAIL redir_t3_oaddr got %0h want 100", oa); end
        vec++; if (oi !== 32'h100 + K) begin miss++; $display("FAIL redir_t3_instr got %0h want %0h", oi, 32'h100 + K); end
        step();
        vec++; if (oa !== 32'h104) begin miss++; $display("FAIL redir_t4_oaddr got %0h want 104", oa); end
    endtask

    task automatic test_redirect_pop();
        hold_reset();
        reset = 1'b0;
        stall = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) step();
        adv();
        stall = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h200;
        #1;
        vec++; if (cnt !== 3'd4) begin miss++; $display("FAIL rpop_pre_count got %0d want 4", cnt); end
        vec++; if (oa !== 32'h0) begin miss++; $display("FAIL rpop_pre_head got %0h want 0", oa); end
        adv();
        redirect = 1'b0;
        #1;
        vec++; if (cnt !== 3'd0) begin miss++; $display("FAIL rpop_t1_count got %0d want 0", cnt); end
        vec++; if (ov !== 1'b0) begin miss++; $display("FAIL rpop_t1_valid got %0h want 0", ov); end
        vec++; if (addr !== 32'h200) begin miss++; $display("FAIL rpop_t1_addr got %0h want 200", addr); end
        step();
        vec++; if (ov !== 1'b0) begin miss++; $display("FAIL rpop_t2_valid got %0h want 0", ov); end
        vec++; if (cnt !== 3'd0) begin miss++; $display("FAIL rpop_t2_count got %0d want 0", cnt); end
        step();
        vec++; if (oa !== 32'h200) begin miss++; $display("FAIL rpop_t3_oaddr got %0h want 200", oa); end
        vec++; if (cnt !== 3'd1) begin miss++; $display("FAIL rpop_t3_count got %0d want 1", cnt); end
        step();
        vec++; if (oa !== 32'h204) begin miss++; $display("FAIL rpop_t4_oaddr got %0h want 204", oa); end
    endtask

    task automatic test_reset_mid();
        hold_reset();
        reset = 1'b0;
        stall = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) step();
        vec++; if (cnt !== 3'd3) begin miss++; $display("FAIL rmid_pre_count got %0d want 3", cnt); end
        #1;
        reset = 1'b1;
        #1;
        vec++; if (ov !== 1'b0) begin miss++; $display("FAIL rmid_valid got %0h want 0", ov); end
        vec++; if (oa !== 32'h0) begin miss++; $display("FAIL rmid_oaddr got %0h want 0", oa); end
        vec++; if (oi !== 32'h0) begin miss++; $display("FAIL rmid_instr got %0h want 0", oi); end
        vec++; if (cnt !== 3'd0) begin miss++; $display("FAIL rmid_count got %0d want 0", cnt); end
        vec++; if (addr !== 32'h0) begin miss++; $display("FAIL rmid_addr got %0h want 0", addr); end
        adv();
        adv();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        vec++; if (req !== 1'b1) begin miss++; $display("FAIL rmid_restart_req got %0h want 1", req); end
        vec++; if (addr !== 32'h0) begin miss++; $display("FAIL rmid_restart_addr got %0h want 0", addr); end
        step();
        step();
        vec++; if (ov !== 1'b1) begin miss++; $display("FAIL rmid_first_valid got %0h want 1", ov); end
        vec++; if (oa !== 32'h0) begin miss++; $display("FAIL rmid_first_oaddr got %0h want 0", oa); end
        vec++; if (cnt !== 3'd1) begin miss++; $display("FAIL rmid_first_count got %0d want 1", cnt); end
    endtask

    task automatic test_wrap();
        hold_reset();
        reset = 1'b0;
        #1;
        vec++; if (w_addr !== 32'hFFFF_FFF8) begin miss++; $display("FAIL wrap_c0_addr got %0h want fffffff8", w_addr); end
        step();
        step();
        vec++; if (w_addr !== 32'h0) begin miss++; $display("FAIL wrap_pc got %0h want 0", w_addr); end
        vec++; if (w_oa !== 32'hFFFF_FFF8) begin miss++; $display("FAIL wrap_o0 got %0h want fffffff8", w_oa); end
        step();
        vec++; if (w_oa !== 32'hFFFF_FFFC) begin miss++; $display("FAIL wrap_o1 got %0h want fffffffc", w_oa); end
        step();
        vec++; if (w_oa !== 32'h0) begin miss++; $display("FAIL wrap_o2 got %0h want 0", w_oa); end
        vec++; if (w_oi !== K) begin miss++; $display("FAIL wrap_i2 got %0h want %0h", w_oi, K); end
        vec++; if (w_cnt !== 3'd1) begin miss++; $display("FAIL wrap_count got %0d want 1", w_cnt); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
